// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer slice.
// Default widths and the controller state encoding.
package mac_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 22;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mac_seq_ctrl_acc.sv
// Unsigned multiply-accumulate register with synchronous clear.
// carry is bit ACC_W of the sum being formed this cycle.
module mac_acc_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic              carry
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    acc_q;

  assign prod  = a * b;
  assign sum   = {1'b0, acc_q}
               + {{(ACC_W+1-2*DATA_W){1'b0}}, prod};
  assign carry = sum[ACC_W];
  assign acc   = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the MAC datapath: operand intake,
// beat counting, result handshake and sticky overflow.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  output logic              busy,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  res_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              ovf
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             res_valid_q;
  logic             busy_q;
  logic             beat;
  logic             clr;
  logic             carry;
  logic [ACC_W-1:0] acc;

  assign beat = in_valid & in_ready_q;
  assign clr  = (state_q == IDLE) & start;

  mac_acc_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (beat),
    .a    (a_in),
    .b    (b_in),
    .acc  (acc),
    .carry(carry)
  );

  // The accumulator register doubles as the result register:
  // it only moves on beats and holds through DONE and IDLE.
  assign res_out   = acc;
  assign res_valid = res_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len != '0) begin
              cnt_q      <= len;
              in_ready_q <= 1'b1;
              state_q    <= RUN;
            end else begin
              res_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        RUN: begin
          if (beat) begin
            ovf_q <= ovf_q | carry;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              in_ready_q  <= 1'b0;
              res_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer for the MAC system. Accepts a job of LEN operand pairs and streams them through an unsigned multiply-accumulate datapath over a valid/ready input port. Presents the 22-bit accumulated result on a valid/ready output port. Sits between the operand source (memory or FIFO) and the result consumer, and owns accumulator clear/enable timing.

Parameters:
DATA_W, 8, width of each unsigned operand a_in/b_in
ACC_W, 22, accumulator and result width
CNT_W, 8, width of job length and beat counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  job request; sampled only in IDLE
len  input  CNT_W  number of operand pairs in the job; sampled with start
busy  output  1  high whenever state != IDLE
a_in  input  DATA_W  operand A
b_in  input  DATA_W  operand B
in_valid  input  1  operand pair valid
in_ready  output  1  controller accepts the pair; high only in RUN
res_out  output  ACC_W  accumulated result
res_valid  output  1  result available; high only in DONE
res_ready  input  1  consumer accepts result
ovf  output  1  sticky: accumulation carried out of ACC_W during the current job

Behaviour:
- Reset (async, rst=1): state=IDLE, accumulator=0, counter=0, res_out=0, res_valid=0, in_ready=0, busy=0, ovf=0. Reset mid-job abandons the job; no partial result is presented.
- States: IDLE, RUN, DONE (encoding in package).
- IDLE: start=1 and len!=0 -> clear accumulator and ovf, load counter=len, go to RUN. start=1 and len==0 -> clear accumulator and ovf, go straight to DONE (result 0). start=0 -> stay; res_out and ovf hold the previous job's values.
- RUN: in_ready=1. A beat is accepted in a cycle where in_valid && in_ready. On each beat: acc <= (acc + a_in*b_in) mod 2^ACC_W, counter decrements. Cycles with in_valid=0 are stalls with no state change.
- Accepting the beat with counter==1 transitions to DONE. res_out and res_valid are registered, so the result including the last product is visible the cycle after the last beat (latency 1).
- DONE: res_valid=1, in_ready=0, res_out stable. res_valid && res_ready -> IDLE on the next edge. res_ready held low -> stay indefinitely with output stable.
- Arithmetic: unsigned product is 2*DATA_W wide, zero-extended to ACC_W+1 for the add. Bit ACC_W of the sum sets ovf (sticky until the next accepted start). The accumulator wraps and never saturates. With defaults, 64 max-value beats cannot overflow; 65 can.
- start while busy (RUN or DONE) is ignored; no queuing.
- In DONE, a res_ready handshake and start in the same cycle: the handshake completes and start is ignored. A start is taken in IDLE on a later cycle.
- len is sampled only on the accepting start edge; later changes have no effect.

Decomposition:
- Shared package mac_pkg: DATA_W/ACC_W/CNT_W defaults, state enumeration (IDLE=0, RUN=1, DONE=2).
- Sub-module mac_acc_unit: multiplier plus accumulator register with clr, en, a, b inputs and acc, carry outputs (same clk/rst convention).
- The FSM, counter, handshakes and result/ovf registers stay in mac_seq_ctrl.

Test Plan:
- len=3; pairs (2,3),(4,5),(10,10) back-to-back with res_ready=1 -> res_valid one cycle after third beat, res_out=126, ovf=0, back to IDLE next cycle, busy low.
- len=2; in_valid gapped 3 cycles between beats (7,8),(1,1); res_ready low 5 cycles -> res_out=57 held stable with res_valid=1 and busy=1 throughout; IDLE after res_ready rises.
- len=0 start -> DONE next cycle, res_out=0, res_valid=1, in_ready never asserted.
- len=65; all beats (255,255) -> ovf=1, res_out=32321 (4226625 mod 2^22). A following len=1 job with (1,1) -> ovf=0, res_out=1.
- Reset pulse after 2 of 4 accepted beats -> all outputs 0 immediately (async), state IDLE. Then len=1 with (7,6) -> res_out=42.
- Pulse start with len=5 during RUN and during DONE (including the handshake cycle) -> ignored; counter and result unaffected, no new job begins.
